// File: rtl/simple_tx.sv
// simple_tx: buffers one byte-stream packet, then frames it on the txd/txen link
// as SFD, type, size, payload (zero-padded to 8) and an 8-bit additive FCS.
module simple_tx #(
    parameter int G_MEM_SIZE = 255,
    parameter int G_IFG      = 12
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  tdata_in,
    input  logic        tvalid_in,
    input  logic        tlast_in,
    output logic        tready_out,
    output logic [7:0]  txd_out,
    output logic        txen_out,
    output logic [15:0] stat_packet_sent_cnt,
    output logic [15:0] stat_packet_err_cnt
);

    localparam int         AW      = $clog2(G_MEM_SIZE);
    localparam logic [7:0] MAX_N   = 8'(G_MEM_SIZE);
    // GAP also covers the two link pipeline stages behind the FSM
    localparam logic [15:0] GAP_END = 16'(G_IFG + 1);

    typedef enum logic [2:0] {
        LOAD, DROP, SFD, TYPE, SIZE, PAYLOAD, FCS, GAP
    } state_t;

    state_t      state, state_nx;
    logic [15:0] phase;
    logic [7:0]  mem [2**AW];
    logic [7:0]  wr_ptr, rd_ptr, n_len, fcs;
    logic [7:0]  size, pay_byte;
    logic        xfer, full, err_inc;
    logic        en_d, last_d;
    logic [7:0]  dat_d;
    logic        en1, last1, last2;
    logic [7:0]  dat1;
    logic        ready_q;

    assign tready_out = ready_q;
    assign xfer       = tvalid_in & ready_q;
    assign full       = (wr_ptr == MAX_N);
    assign size       = (n_len < 8'd8) ? 8'd8 : n_len;
    assign pay_byte   = (rd_ptr < n_len) ? mem[rd_ptr[AW-1:0]] : 8'h00;
    assign err_inc    = xfer & tlast_in &
                        ((state == DROP) | ((state == LOAD) & full));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= LOAD;
            phase <= '0;
        end else begin
            state <= state_nx;
            phase <= (state_nx != state) ? 16'd0 : phase + 16'd1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD: begin
                if (xfer) begin
                    if (full)
                        state_nx = tlast_in ? LOAD : DROP;
                    else if (tlast_in)
                        state_nx = SFD;
                end
            end
            DROP:    if (xfer && tlast_in) state_nx = LOAD;
            SFD:     if (phase == 16'd3) state_nx = TYPE;
            TYPE:    if (phase == 16'd1) state_nx = SIZE;
            SIZE:    state_nx = PAYLOAD;
            PAYLOAD: if (rd_ptr == size - 8'd1) state_nx = FCS;
            FCS:     state_nx = GAP;
            GAP:     if (phase == GAP_END) state_nx = LOAD;
        endcase
    end

    always_comb begin
        en_d   = 1'b0;
        dat_d  = 8'h00;
        last_d = 1'b0;
        unique case (state)
            SFD: begin
                en_d  = 1'b1;
                dat_d = (phase == 16'd3) ? 8'h7F : 8'h55;
            end
            TYPE: begin
                en_d  = 1'b1;
                dat_d = (phase == 16'd0) ? 8'h12 : 8'h34;
            end
            SIZE: begin
                en_d  = 1'b1;
                dat_d = size;
            end
            PAYLOAD: begin
                en_d  = 1'b1;
                dat_d = pay_byte;
            end
            FCS: begin
                en_d   = 1'b1;
                dat_d  = fcs;
                last_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (state == LOAD && xfer && !full)
            mem[wr_ptr[AW-1:0]] <= tdata_in;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            n_len  <= '0;
            fcs    <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (xfer) begin
                        if (full) begin
                            if (tlast_in) wr_ptr <= '0;
                        end else begin
                            wr_ptr <= wr_ptr + 8'd1;
                            if (tlast_in) n_len <= wr_ptr + 8'd1;
                        end
                    end
                end
                DROP:    if (xfer && tlast_in) wr_ptr <= '0;
                SIZE:    fcs <= size;
                PAYLOAD: begin
                    fcs    <= fcs + pay_byte;
                    rd_ptr <= rd_ptr + 8'd1;
                end
                GAP: begin
                    if (state_nx == LOAD) begin
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            en1      <= 1'b0;
            dat1     <= '0;
            last1    <= 1'b0;
            txen_out <= 1'b0;
            txd_out  <= '0;
            last2    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            en1      <= en_d;
            dat1     <= dat_d;
            last1    <= last_d;
            txen_out <= en1;
            txd_out  <= dat1;
            last2    <= last1;
            ready_q  <= (state_nx == LOAD) || (state_nx == DROP);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stat_packet_sent_cnt <= '0;
            stat_packet_err_cnt  <= '0;
        end else begin
            if (last2 && stat_packet_sent_cnt != 16'hFFFF)
                stat_packet_sent_cnt <= stat_packet_sent_cnt + 16'd1;
            if (err_inc && stat_packet_err_cnt != 16'hFFFF)
                stat_packet_err_cnt <= stat_packet_err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_simple_tx.sv
// tb_simple_tx: directed stimulus for simple_tx with a link monitor that
// collects transmitted frames and checks them against hand-built expectations.
module tb_simple_tx;

    localparam int MEM = 20;
    localparam int IFG = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tdata = 8'h00;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        tready;
    logic [7:0]  txd;
    logic        txen;
    logic [15:0] sent_cnt, err_cnt;

    simple_tx #(.G_MEM_SIZE(MEM), .G_IFG(IFG)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .tdata_in(tdata),
        .tvalid_in(tvalid),
        .tlast_in(tlast),
        .tready_out(tready),
        .txd_out(txd),
        .txen_out(txen),
        .stat_packet_sent_cnt(sent_cnt),
        .stat_packet_err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int stalls = 0;

    logic [7:0] link[$];
    int         flen[$];
    logic [7:0] cur[$];
    int   cyc = 0;
    int   last_en = -1000;
    int   rdy_gap = -1;
    int   idle_gap = -1;
    int   idle_bad = 0;
    logic prev_rdy = 1'b0;
    logic prev_en = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            cur.delete();
        end else if (txen) begin
            if (!prev_en) idle_gap = cyc - last_en - 1;
            cur.push_back(txd);
            last_en = cyc;
        end else begin
            if (txd !== 8'h00) idle_bad++;
            if (cur.size() > 0) begin
                foreach (cur[i]) link.push_back(cur[i]);
                flen.push_back(cur.size());
                cur.delete();
            end
        end
        if (tready && !prev_rdy) rdy_gap = cyc - last_en;
        prev_rdy = tready;
        prev_en  = txen;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] p[$], input bit gaps,
                        input bit hold);
        int w;
        for (int i = 0; i < p.size(); i++) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 1) == 1) begin
                tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            tdata  = p[i];
            tvalid = 1'b1;
            tlast  = (i == p.size() - 1);
            w = 0;
            while (!tready && w < 500) begin
                @(negedge clk);
                w++;
            end
            stalls += w;
            if (w >= 500) chk("send_timeout", 32'(w), 32'd0);
            @(posedge clk);
        end
        if (!hold) begin
            @(negedge clk);
            tvalid = 1'b0;
            tlast  = 1'b0;
        end
    endtask

    task automatic mk_frame(input logic [7:0] p[$], output logic [7:0] f[$]);
        logic [7:0] sz, sum, b;
        sz = (p.size() < 8) ? 8'd8 : 8'(p.size());
        f = '{8'h55, 8'h55, 8'h55, 8'h7F, 8'h12, 8'h34};
        f.push_back(sz);
        sum = sz;
        for (int i = 0; i < int'(sz); i++) begin
            b = (i < p.size()) ? p[i] : 8'h00;
            f.push_back(b);
            sum = sum + b;
        end
        f.push_back(sum);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] e[$]);
        int w = 0;
        int n;
        int bad = -1;
        logic [7:0] got[$];
        while (flen.size() == 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (flen.size() == 0) begin
            chk({tag, "_timeout"}, 32'(w), 32'd0);
            return;
        end
        n = flen.pop_front();
        for (int i = 0; i < n; i++) got.push_back(link.pop_front());
        chk({tag, "_len"}, 32'(n), 32'(e.size()));
        for (int i = 0; i < n && i < e.size(); i++)
            if (got[i] !== e[i] && bad < 0) bad = i;
        if (bad >= 0)
            $display("  %s byte %0d got %0h want %0h", tag, bad, got[bad], e[bad]);
        chk({tag, "_first_bad_idx"}, 32'(bad), 32'hFFFF_FFFF);
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!tready && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) chk("ready_timeout", 32'(w), 32'd0);
    endtask

    logic [7:0] pay[$];
    logic [7:0] pb[$];
    logic [7:0] exp_f[$];
    logic [7:0] exp_g[$];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", 32'(tready), 32'd0);
        chk("rst_txen", 32'(txen), 32'd0);
        chk("rst_txd", 32'(txd), 32'd0);
        chk("rst_sent", 32'(sent_cnt), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("tready_before_edge", 32'(tready), 32'd0);
        @(posedge clk);
        #1 chk("tready_after_edge", 32'(tready), 32'd1);

        pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send(pay, 1'b0, 1'b0);
        @(posedge clk);
        #1 chk("lat_edge1_txen", 32'(txen), 32'd0);
        @(posedge clk);
        #1 chk("lat_edge2_txen", 32'(txen), 32'd1);
        chk("tready_low_tx", 32'(tready), 32'd0);
        exp_f = '{8'h55, 8'h55, 8'h55, 8'h7F, 8'h12, 8'h34, 8'h08,
                  8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                  8'h2C};
        check_frame("n8", exp_f);
        chk("sent_1", 32'(sent_cnt), 32'd1);
        wait_ready();

        pay = '{8'hAA};
        send(pay, 1'b0, 1'b0);
        exp_f = '{8'h55, 8'h55, 8'h55, 8'h7F, 8'h12, 8'h34, 8'h08,
                  8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'hB2};
        check_frame("n1", exp_f);
        chk("sent_2", 32'(sent_cnt), 32'd2);
        wait_ready();

        pay.delete();
        for (int i = 0; i < MEM + 2; i++) pay.push_back(8'(8'h40 + i));
        stalls = 0;
        send(pay, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        chk("drop_no_link", 32'(flen.size() + cur.size()), 32'd0);
        chk("drop_stalls", 32'(stalls), 32'd0);
        chk("drop_err", 32'(err_cnt), 32'd1);
        chk("drop_sent", 32'(sent_cnt), 32'd2);
        pay = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        send(pay, 1'b0, 1'b0);
        mk_frame(pay, exp_f);
        check_frame("after_drop", exp_f);
        wait_ready();

        pay.delete();
        for (int i = 0; i < MEM; i++) pay.push_back(8'(i * 7 + 3));
        send(pay, 1'b1, 1'b0);
        mk_frame(pay, exp_f);
        chk("max_size_field", 32'(exp_f[6]), 32'h14);
        check_frame("max_gaps", exp_f);
        chk("max_err", 32'(err_cnt), 32'd1);
        wait_ready();

        pay = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        pb  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        send(pay, 1'b0, 1'b1);
        send(pb, 1'b0, 1'b0);
        chk("b2b_ready_return", 32'(rdy_gap), 32'(IFG + 1));
        mk_frame(pay, exp_f);
        mk_frame(pb, exp_g);
        check_frame("b2b_a", exp_f);
        check_frame("b2b_b", exp_g);
        chk("b2b_ifg", 32'(idle_gap >= IFG), 32'd1);
        chk("b2b_sent", 32'(sent_cnt), 32'd6);
        wait_ready();

        pay = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58};
        send(pay, 1'b0, 1'b0);
        begin
            int w = 0;
            while (!txen && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (w >= 100) chk("rst_wait_txen", 32'(w), 32'd0);
        end
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_txen", 32'(txen), 32'd0);
        chk("arst_txd", 32'(txd), 32'd0);
        chk("arst_tready", 32'(tready), 32'd0);
        chk("arst_sent", 32'(sent_cnt), 32'd0);
        chk("arst_err", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        wait_ready();
        chk("arst_no_frame", 32'(flen.size()), 32'd0);
        pay = '{8'hC1, 8'hC2, 8'hC3};
        send(pay, 1'b0, 1'b0);
        mk_frame(pay, exp_f);
        check_frame("post_rst", exp_f);
        chk("post_rst_sent", 32'(sent_cnt), 32'd1);

        chk("idle_txd_zero", 32'(idle_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
